// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters sharing one decoder-selected resource.
// Registered one-hot grant plus binary index, grant/release handshake and hold timeout.
module rr_arbiter_8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    // First set request bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] sel;
        logic [2:0] cand;
        sel = p;
        for (int i = 7; i >= 0; i--) begin
            cand = p + 3'(i);
            if (r[cand]) begin
                sel = cand;
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    function automatic logic [7:0] dec3(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    state_t     state_r;
    logic [2:0] ptr_r;
    logic [7:0] cnt_r;
    logic [7:0] gnt_r;
    logic [2:0] gnt_idx_r;
    logic       gnt_valid_r;
    logic       timeout_r;

    logic [2:0] pick_s;
    logic       any_req_s;
    logic       rel_drop_s;
    logic       rel_hold_s;
    logic       advance_s;
    logic       release_s;
    logic       to_s;
    logic [7:0] cnt_next_s;

    // Selection and release-cause decode for the current cycle.
    always_comb begin
        pick_s     = rr_pick(req, ptr_r);
        any_req_s  = |req;
        rel_drop_s = ~req[gnt_idx_r];
        rel_hold_s = (cnt_r == HOLD_LIM);
        advance_s  = done | rel_drop_s | rel_hold_s;
        release_s  = advance_s | ~en;
        // A forced release only counts as a timeout when nobody let go voluntarily.
        to_s       = rel_hold_s & ~done & ~rel_drop_s;
        if (cnt_r == 8'hFF) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + 8'd1;
        end
    end

    // Arbiter FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= 3'd0;
            cnt_r       <= 8'd0;
            gnt_r       <= 8'h00;
            gnt_idx_r   <= 3'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    timeout_r <= 1'b0;
                    if (en && any_req_s) begin
                        state_r     <= GRANT;
                        gnt_idx_r   <= pick_s;
                        gnt_r       <= dec3(pick_s);
                        gnt_valid_r <= 1'b1;
                        cnt_r       <= 8'd1;
                    end else begin
                        state_r     <= IDLE;
                        gnt_r       <= 8'h00;
                        gnt_valid_r <= 1'b0;
                        cnt_r       <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        state_r     <= IDLE;
                        gnt_r       <= 8'h00;
                        gnt_valid_r <= 1'b0;
                        cnt_r       <= 8'd0;
                        timeout_r   <= to_s;
                        // Disabling alone keeps the holder first in line.
                        if (advance_s) begin
                            ptr_r <= gnt_idx_r + 3'd1;
                        end else begin
                            ptr_r <= ptr_r;
                        end
                    end else begin
                        state_r   <= GRANT;
                        cnt_r     <= cnt_next_s;
                        timeout_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 8'd0;
                    gnt_r       <= 8'h00;
                    gnt_valid_r <= 1'b0;
                    timeout_r   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

    rr_arbiter_8_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .gnt       (gnt_r),
        .gnt_idx   (gnt_idx_r),
        .gnt_valid (gnt_valid_r),
        .timeout   (timeout_r)
    );

endmodule

// Output invariants of the arbiter: one-hot grant matching the index, idle timeout only.
module rr_arbiter_8_chk (
    input logic       clk,
    input logic       rst,
    input logic [7:0] gnt,
    input logic [2:0] gnt_idx,
    input logic       gnt_valid,
    input logic       timeout
);

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        gnt_valid |-> (gnt == (8'h01 << gnt_idx)));

    a_zero: assert property (@(posedge clk) disable iff (rst)
        !gnt_valid |-> (gnt == 8'h00));

    a_to_idle: assert property (@(posedge clk) disable iff (rst)
        timeout |-> !gnt_valid);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8 (HOLD_MAX=4): directed stimulus queues expected
// grants (index, length, timeout); a monitor checks each completed grant.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        int idx;
        int len;
        int to;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    bit   mon_en;

    rr_arbiter_8 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int len, input int to);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt_valid !== 1'b1 && n < 50);
        check(name, {31'd0, gnt_valid}, 1);
    endtask

    task automatic idle_gap();
        req  = 8'h00;
        done = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: measures each grant and compares it with the scoreboard head.
    initial begin
        int   cur_idx;
        int   cur_len;
        bit   prev_valid;
        exp_t e;
        cur_idx    = 0;
        cur_len    = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (gnt_valid === 1'b1) begin
                    check("gnt_onehot", gnt, 8'h01 << gnt_idx);
                    check("timeout_in_grant", timeout, 0);
                    if (!prev_valid) begin
                        cur_idx = gnt_idx;
                        cur_len = 1;
                    end else begin
                        cur_len++;
                    end
                end else begin
                    check("gnt_zero", gnt, 8'h00);
                    if (prev_valid) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_grant_idx", cur_idx, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("grant_idx", cur_idx, e.idx);
                            check("grant_len", cur_len, e.len);
                            check("grant_timeout", timeout, e.to);
                        end
                    end else begin
                        check("timeout_idle", timeout, 0);
                    end
                end
                prev_valid = (gnt_valid === 1'b1);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        en     = 1'b1;
        req    = 8'hFF;
        done   = 1'b1;

        // Reset held two cycles with every request active.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 8'h00);
        check("rst_gnt_valid", gnt_valid, 0);
        check("rst_gnt_idx", gnt_idx, 0);
        check("rst_timeout", timeout, 0);

        // Full rotation 0..7,0 with done held: one-cycle grants, one idle cycle each.
        for (int k = 0; k < 9; k++) begin
            push(k % 8, 1, 0);
        end
        mon_en = 1'b1;
        rst    = 1'b0;
        drain("rotation");
        idle_gap();

        // Sparse requesters 2 and 7 alternate, pointer wraps after 7.
        push(2, 1, 0);
        push(7, 1, 0);
        push(2, 1, 0);
        push(7, 1, 0);
        done = 1'b1;
        req  = 8'b1000_0100;
        drain("sparse");
        idle_gap();

        // Requester 3 holds without done: forced release after 4 cycles, twice.
        push(3, 4, 1);
        push(3, 4, 1);
        req = 8'h08;
        drain("timeout");
        idle_gap();

        // done on the same cycle the counter hits the limit: no timeout.
        push(4, 4, 0);
        req = 8'h10;
        wait_grant("wait_grant_4");
        repeat (3) @(posedge clk);
        #1;
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        req  = 8'h00;
        drain("done_at_limit");
        idle_gap();

        // Disable mid-grant of 5: pointer stays, so 5 wins again against all.
        push(5, 2, 0);
        push(5, 1, 0);
        req = 8'h20;
        wait_grant("wait_grant_5");
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        en   = 1'b1;
        req  = 8'hFF;
        done = 1'b1;
        drain("disable_mid_grant");
        idle_gap();

        // Reset during a grant to 6: grant drops, pointer returns to 0.
        push(6, 2, 0);
        push(0, 1, 0);
        req = 8'h40;
        wait_grant("wait_grant_6");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        req  = 8'hFF;
        done = 1'b1;
        drain("reset_mid_grant");
        idle_gap();

        // Disabled arbiter ignores requests; re-enabled it grants 1 and times out.
        en   = 1'b0;
        req  = 8'hFF;
        done = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("disabled_gnt_valid", gnt_valid, 0);
        check("disabled_gnt", gnt, 8'h00);
        push(1, 4, 1);
        en = 1'b1;
        drain("reenable_timeout");
        idle_gap();
        repeat (3) @(posedge clk);
        #1;
        check("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Resource select lines are driven by the registered 3-bit grant index plus a one-hot grant vector, equivalent to a 3-to-8 decode of the index gated by grant-valid.
- Provides a grant/release handshake, fair rotation and a hold-timeout so no requester can starve the others.
- Sits between requester logic and the shared decoder-selected resource.

Parameters:
- HOLD_MAX, 16, maximum number of cycles a grant may be held before forced release. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global arbiter enable.
- req  input  8  request vector; bit n = requester n.
- done  input  1  release strobe from the currently granted requester.
- gnt  output  8  one-hot grant, registered; all zeros when no grant.
- gnt_idx  output  3  binary index of the granted requester, registered.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Behaviour:
- Reset (rst=1 at a clock edge):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Internal priority pointer ptr=3'd0, hold counter=0, FSM in IDLE.
  - rst overrides every other input, including mid-grant; the grant drops on the reset edge.
- FSM states: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0, select the first set req bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
  - Next cycle: gnt_idx=selected, gnt=1<<selected, gnt_valid=1, counter=1, state GRANT.
  - Latency from req sampled to gnt visible is 1 cycle.
  - If en=0 or req=0, stay in IDLE with all outputs zero.
- GRANT: release occurs on the first cycle where any of the following holds:
  - (a) done=1
  - (b) req[gnt_idx]=0
  - (c) counter==HOLD_MAX
  - (d) en=0
- On release, next cycle: gnt=0, gnt_valid=0, state IDLE.
  - For (a), (b) and (c), ptr=gnt_idx+1 (3-bit wrap; 7 -> 0).
  - For (d), ptr is unchanged.
  - timeout=1 for exactly that one cycle only when (c) is the cause and (a) and (b) are both false.
- Priority when several release causes occur together: the pointer advances if any of (a), (b) or (c) is true, even if en=0 at the same time. timeout is suppressed whenever done=1 or the request drops on the same cycle.
- Hold counter:
  - Increments by 1 each GRANT cycle without release.
  - 8-bit, saturating, never wraps.
  - Cleared in IDLE.
  - HOLD_MAX=1 means the grant lasts exactly 1 cycle.
- gnt_idx holds its last value after release; consumers must qualify it with gnt_valid.
- gnt is always either zero or exactly one-hot and equal to 1<<gnt_idx while gnt_valid=1.
- Each grant is followed by at least one IDLE cycle. The maximum grant rate is one per 2 cycles.
- Requests arriving in GRANT are ignored until IDLE. The arbiter does not preempt an active grant.
- done sampled in IDLE has no effect.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF, en=1 -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0. First grant after rst deasserts goes to requester 0 (gnt=8'h01) one cycle later.
- Rotation: en=1, req=8'hFF held, done pulsed 1 cycle after each grant -> grants in order 0,1,2,...,7,0. gnt values 8'h01, 8'h02, ..., 8'h80, 8'h01. Exactly one idle cycle between grants.
- Sparse fairness: req=8'b1000_0100, done pulsed each grant -> grants alternate 2,7,2,7. After granting 7, ptr wraps to 0 and the next grant is 2.
- Timeout: HOLD_MAX=4, req=8'h08 held, done=0 -> gnt=8'h08 for exactly 4 cycles, then timeout=1 for one cycle with gnt=0. Regrant to 3 after the idle cycle.
- Simultaneous causes:
  - done=1 on the same cycle counter==HOLD_MAX -> release with timeout=0.
  - en=0 mid-grant of requester 5 -> gnt drops next cycle and ptr stays 5. With en=1 again and req=8'hFF, the next grant is 5.
- Reset mid-grant: grant active on requester 6, rst=1 for one cycle -> gnt=0 on that edge. With req=8'hFF, the next grant is requester 0.
